// File: rtl/decimal_countdown_timer.sv
// Four-digit BCD countdown timer with load/start/pause control and a prescaled tick.
// The count is clamped to valid BCD on load and stops at 0000 with a sticky done flag.
module decimal_countdown_timer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iLoad,
    input  logic [15:0] iPreset,
    input  logic        iStart,
    input  logic        iPause,
    output logic [15:0] oDigit,
    output logic        oRunning,
    output logic        oDone,
    output logic        oDonePulse
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     digit_q, digit_d;
    logic            pulse_q, pulse_d;
    logic            tick;

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        logic [3:0]  n;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            n = v[i*4 +: 4];
            r[i*4 +: 4] = (n > 4'd9) ? 4'd9 : n;
        end
        return r;
    endfunction

    // Ripple borrow from the least significant digit upward.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic [3:0]  n;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = v[i*4 +: 4];
            if (borrow) begin
                if (n == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = n - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            digit_q <= 16'h0000;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            pulse_q <= pulse_d;
        end
    end

    // Next state; load overrides everything, pause is only honoured in RUN.
    always_comb begin
        state_d = state_q;
        if (iLoad) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (iStart && (digit_q != 16'h0000)) state_d = ST_RUN;
                ST_RUN: begin
                    if (iPause)                                  state_d = ST_PAUSE;
                    else if (tick && (digit_q == 16'h0001))      state_d = ST_DONE;
                end
                ST_PAUSE: if (iStart) state_d = ST_RUN;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: prescaler, count and completion pulse.
    always_comb begin
        presc_d = presc_q;
        digit_d = digit_q;
        pulse_d = 1'b0;
        if (iLoad) begin
            digit_d = clamp_bcd(iPreset);
            presc_d = '0;
        end else if ((state_q == ST_IDLE) && iStart && (digit_q != 16'h0000)) begin
            presc_d = '0;
        end else if ((state_q == ST_RUN) && !iPause) begin
            if (tick) begin
                presc_d = '0;
                digit_d = bcd_dec(digit_q);
                pulse_d = (digit_q == 16'h0001);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_comb begin
        oDigit     = digit_q;
        oRunning   = (state_q == ST_RUN);
        oDone      = (state_q == ST_DONE);
        oDonePulse = pulse_q;
    end

endmodule
